// File: rtl/asrv32_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
// Acknowledge and read data are valid in the same cycle.
interface asrv32_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/asrv32_fetch.sv
// Instruction-fetch unit: owns the PC, issues one imem request per FETCH visit,
// and returns the word with a one-cycle valid pulse.
//
//   state | meaning
//   IDLE  | no bus transaction outstanding
//   REQ   | request held on the bus, waiting for ack
module asrv32_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_fetch_en,
  input  logic                  i_writeback_en,
  input  logic                  i_change_pc,
  input  logic [31:0]           i_next_pc,
  input  logic                  i_redirect,
  input  logic [31:0]           i_redirect_pc,
  output logic [31:0]           o_pc,
  asrv32_fetch_if.master        imem,
  output logic [31:0]           o_inst,
  output logic                  o_inst_valid,
  output logic                  o_stall,
  output logic                  o_misaligned
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic        r_imem_req;
  logic [31:0] r_imem_addr;
  logic [31:0] r_inst;
  logic        r_inst_valid;
  logic        r_discard;

  logic        w_misaligned;
  logic        w_issue;
  logic        w_accept;
  logic        w_drop;

  assign w_misaligned = |r_pc[1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      IDLE: begin
        // The valid-cycle guard keeps one fetch per FETCH visit.
        if (i_fetch_en && !w_misaligned && !i_redirect && !r_inst_valid) begin
          w_issue     = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (imem.imem_ack) begin
          // A word returning alongside or after a redirect belongs to the old path.
          if (r_discard || i_redirect) begin
            w_drop = 1'b1;
          end else begin
            w_accept = 1'b1;
          end
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_imem_req   <= 1'b0;
      r_imem_addr  <= PC_RESET;
      r_inst       <= 32'h0;
      r_inst_valid <= 1'b0;
      r_discard    <= 1'b0;
    end else begin
      r_inst_valid <= w_accept;
      if (w_issue) begin
        r_imem_req  <= 1'b1;
        r_imem_addr <= r_pc;
      end else if (w_accept || w_drop) begin
        r_imem_req  <= 1'b0;
      end
      if (w_accept) begin
        r_inst <= imem.imem_rdata;
      end
      if (w_accept || w_drop) begin
        r_discard <= 1'b0;
      end else if (r_state == REQ && i_redirect) begin
        r_discard <= 1'b1;
      end
    end
  end

  // Redirect outranks a simultaneous writeback commit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= PC_RESET;
    end else if (i_redirect) begin
      r_pc <= i_redirect_pc;
    end else if (i_writeback_en) begin
      r_pc <= i_change_pc ? i_next_pc : r_pc + 32'd4;
    end
  end

  assign o_pc           = r_pc;
  assign imem.imem_req  = r_imem_req;
  assign imem.imem_addr = r_imem_addr;
  assign o_inst         = r_inst;
  assign o_inst_valid   = r_inst_valid;
  assign o_misaligned   = w_misaligned;
  assign o_stall        = i_fetch_en & ~r_inst_valid & ~w_misaligned;

endmodule
